// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the streaming priority encoder.
// Optional one-hot grant output is enabled with PRIO_ENC_ONEHOT_EN.
package prio_enc_pkg;

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_encoder_stream_pick.sv
// Combinational winner search over a request mask (fixed or round-robin).
// Used by prio_encoder_stream; PRIO_ENC_ONEHOT_EN has no effect here.
module prio_pick
   import prio_enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_FIXED,
   parameter int W    = clog2_min1(N)
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] winner,
   output logic         found,
   output logic         single
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   int j;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      j      = 0;
      if (MODE == MODE_RR) begin
         // walk ptr-1 down to 0, then wrap N-1 down to ptr
         for (int k = 1; k <= N; k++) begin
            j = int'(ptr) - k;
            if (j < 0) j = j + N;
            if (!found && pending[j]) begin
               found  = 1'b1;
               winner = j[W-1:0];
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
               found  = 1'b1;
               winner = i[W-1:0];
            end
         end
      end
      single = (pending != '0) && ((pending & (pending - ONE)) == '0);
   end

endmodule

// File: rtl/prio_encoder_stream.sv
// Registered streaming priority encoder: one index beat per set request bit.
// Define PRIO_ENC_ONEHOT_EN to add the grant_oh one-hot output port.
module prio_encoder_stream
   import prio_enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_FIXED,
   localparam int W   = clog2_min1(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [N-1:0] req,
   input  logic         req_valid,
   output logic         req_ready,
   output logic [W-1:0] idx_out,
   output logic         any,
   output logic         last,
   output logic         out_valid,
   input  logic         out_ready
`ifdef PRIO_ENC_ONEHOT_EN
   ,
   output logic [N-1:0] grant_oh
`endif
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t       state;
   logic [N-1:0] pending;
   logic [N-1:0] cleared;
   logic [N-1:0] src;
   logic [W-1:0] ptr;
   logic [W-1:0] pick_ptr;
   logic [W-1:0] win;
   logic         found;
   logic         single;
   logic         take_req;
   logic         take_beat;

   assign req_ready = (state == IDLE) && enable && !reset;
   assign take_req  = req_valid && req_ready;
   assign take_beat = out_valid && out_ready;

   // IDLE picks the first beat from req; DRAIN looks ahead past the current beat
   always_comb begin
      cleared  = pending & ~(ONE << idx_out);
      src      = req;
      pick_ptr = ptr;
      if (state == DRAIN) begin
         src = cleared;
         if (MODE == MODE_RR && any) pick_ptr = idx_out;
      end
   end

   prio_pick #(
      .N    (N),
      .MODE (MODE),
      .W    (W)
   ) u_pick (
      .pending (src),
      .ptr     (pick_ptr),
      .winner  (win),
      .found   (found),
      .single  (single)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pending   <= '0;
         ptr       <= W'(N - 1);
         idx_out   <= '0;
         any       <= 1'b0;
         last      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take_req) begin
                  pending   <= req;
                  idx_out   <= win;
                  any       <= found;
                  last      <= single || !found;
                  out_valid <= 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (take_beat) begin
                  pending <= cleared;
                  if (MODE == MODE_RR && any) ptr <= idx_out;
                  if (last) begin
                     out_valid <= 1'b0;
                     idx_out   <= '0;
                     any       <= 1'b0;
                     last      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     idx_out <= win;
                     any     <= found;
                     last    <= single;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PRIO_ENC_ONEHOT_EN
   assign grant_oh = (out_valid && any && !reset) ? (ONE << idx_out) : '0;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed bench: fixed (u0) and round-robin (u1) encoders on shared stimulus.
// Covers PRIO_ENC_ONEHOT_EN when defined.
module tb_prio_encoder_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] req;
   logic       req_valid;
   logic       out_ready;
   logic       rdy0, rdy1;
   logic [2:0] idx0, idx1;
   logic       any0, any1;
   logic       last0, last1;
   logic       ov0, ov1;
`ifdef PRIO_ENC_ONEHOT_EN
   logic [7:0] oh0, oh1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prio_encoder_stream #(.N(8), .MODE(0)) u0 (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (rdy0),
      .idx_out   (idx0),
      .any       (any0),
      .last      (last0),
      .out_valid (ov0),
      .out_ready (out_ready)
`ifdef PRIO_ENC_ONEHOT_EN
      ,
      .grant_oh  (oh0)
`endif
   );

   prio_encoder_stream #(.N(8), .MODE(1)) u1 (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (rdy1),
      .idx_out   (idx1),
      .any       (any1),
      .last      (last1),
      .out_valid (ov1),
      .out_ready (out_ready)
`ifdef PRIO_ENC_ONEHOT_EN
      ,
      .grant_oh  (oh1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      req       = v;
      req_valid = 1'b1;
      #1;
      chk("send_rdy0", rdy0, 1'b1);
      chk("send_rdy1", rdy1, 1'b1);
      cyc();
      req_valid = 1'b0;
   endtask

   // e0/e1 hold expected indices as hex nibbles, first beat leftmost
   task automatic expect_beats(input int n, input logic [31:0] e0,
                               input logic [31:0] e1, input logic a,
                               input int stall_at);
      logic [2:0] x0, x1;
      logic       l;
      for (int k = 0; k < n; k++) begin
         x0 = e0[4*(n-1-k) +: 3];
         x1 = e1[4*(n-1-k) +: 3];
         l  = (k == n - 1);
         chk("valid0", ov0, 1'b1);
         chk("valid1", ov1, 1'b1);
         chk("idx0", idx0, x0);
         chk("idx1", idx1, x1);
         chk("any0", any0, a);
         chk("last0", last0, l);
         chk("last1", last1, l);
`ifdef PRIO_ENC_ONEHOT_EN
         chk("oh0", oh0, a ? (8'b1 << x0) : 8'h00);
         chk("oh1", oh1, a ? (8'b1 << x1) : 8'h00);
`endif
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (5) begin
               cyc();
               chk("stall_v", ov0, 1'b1);
               chk("stall_idx", idx0, x0);
               chk("stall_last", last0, l);
               chk("stall_idx1", idx1, x1);
            end
            out_ready = 1'b1;
         end
         cyc();
      end
      chk("done_v0", ov0, 1'b0);
      chk("done_v1", ov1, 1'b0);
      chk("done_rdy", rdy0, enable);
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b1;
      req       = 8'h00;
      req_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("rst_valid", ov0, 1'b0);
      chk("rst_idx", idx0, 3'd0);
      chk("rst_any", any0, 1'b0);
      chk("rst_last", last0, 1'b0);
      chk("rst_rdy", rdy0, 1'b0);
      reset = 1'b0;
      #1;
      chk("post_rst_rdy", rdy0, 1'b1);
      cyc();

      // fixed: 7,5,2   rr from ptr=7: 5,2,7
      send(8'b1010_0100);
      expect_beats(3, 32'h752, 32'h527, 1'b1, -1);

      // all-zero: one beat, ptr stays 7
      send(8'h00);
      expect_beats(1, 32'h0, 32'h0, 1'b0, -1);

      // rr ptr=7: 0 then 7 (ptr unchanged by zero vector)
      send(8'b1000_0001);
      expect_beats(2, 32'h70, 32'h07, 1'b1, -1);

      // rr ptr=7 -> 1, 7
      send(8'b1000_0010);
      expect_beats(2, 32'h71, 32'h17, 1'b1, -1);

      // backpressure on 8'hFF, stall at third beat
      send(8'hFF);
      expect_beats(8, 32'h76543210, 32'h65432107, 1'b1, 2);

      // enable=0 blocks capture
      enable    = 1'b0;
      req       = 8'h0C;
      req_valid = 1'b1;
      #1;
      chk("en0_rdy", rdy0, 1'b0);
      repeat (3) cyc();
      chk("en0_nocap", ov0, 1'b0);
      req_valid = 1'b0;
      enable    = 1'b1;
      cyc();

      // capture, then drop enable while draining
      send(8'h0C);
      enable = 1'b0;
      #1;
      chk("drain_rdy", rdy0, 1'b0);
      expect_beats(2, 32'h32, 32'h32, 1'b1, -1);
      enable = 1'b1;
      cyc();

      // reset after two accepted beats of 8'hF0
      send(8'hF0);
      chk("f0_idx0", idx0, 3'd7);
      chk("f0_idx1", idx1, 3'd7);
      cyc();
      chk("f0_idx0b", idx0, 3'd6);
      chk("f0_idx1b", idx1, 3'd6);
      cyc();
      reset = 1'b1;
      cyc();
      chk("mid_rst_v0", ov0, 1'b0);
      chk("mid_rst_v1", ov1, 1'b0);
      chk("mid_rst_rdy", rdy0, 1'b0);
`ifdef PRIO_ENC_ONEHOT_EN
      chk("mid_rst_oh", oh0, 8'h00);
`endif
      reset = 1'b0;
      repeat (3) begin
         cyc();
         chk("no_beats", ov0, 1'b0);
      end
      chk("idle_rdy", rdy0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
